// File: rtl/free_list_ckpt_if.sv
// Rename-stage <-> free-list bundle: allocation request/response, release
// lanes, commit/flush control and status. The rename stage is the master.
interface free_list_ckpt_if #(
  parameter int NUM_PREG = 64,
  parameter int ALLOC_W  = 4,
  parameter int REL_W    = 4,
  parameter int TAG_W    = $clog2(NUM_PREG),
  parameter int CNT_W    = $clog2(NUM_PREG) + 1,
  parameter int AC_W     = $clog2(ALLOC_W) + 1
);
  logic [AC_W-1:0]          alloc_cnt;
  logic                     alloc_en;
  logic [ALLOC_W*TAG_W-1:0] alloc_tag;
  logic                     alloc_ok;
  logic [REL_W-1:0]         rel_valid;
  logic [REL_W*TAG_W-1:0]   rel_tag;
  logic [AC_W-1:0]          commit_cnt;
  logic                     flush;
  logic [CNT_W-1:0]         free_count;
  logic                     empty;
  logic                     overflow_err;

  modport master (
    output alloc_cnt, alloc_en, rel_valid, rel_tag, commit_cnt, flush,
    input  alloc_tag, alloc_ok, free_count, empty, overflow_err
  );

  modport slave (
    input  alloc_cnt, alloc_en, rel_valid, rel_tag, commit_cnt, flush,
    output alloc_tag, alloc_ok, free_count, empty, overflow_err
  );
endinterface

// File: rtl/free_list_ckpt.sv
// Physical-register free list with a speculative head for allocation, a
// committed head for one-cycle flush recovery, and a multi-lane release tail.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module free_list_ckpt #(
  parameter int NUM_PREG = 64,
  parameter int NUM_AREG = 32,
  parameter int ALLOC_W  = 4,
  parameter int REL_W    = 4,
  parameter int TAG_W    = $clog2(NUM_PREG),
  parameter int CNT_W    = $clog2(NUM_PREG) + 1
) (
  input  logic               clk,
  input  logic               reset,
  free_list_ckpt_if.slave    bus
);

  logic [TAG_W-1:0] r_ram [NUM_PREG];
  logic [CNT_W-1:0] r_spec_head;
  logic [CNT_W-1:0] r_cmt_head;
  logic [CNT_W-1:0] r_tail;
  logic             r_overflow_err;

  logic [CNT_W-1:0] w_free_count;
  logic [CNT_W-1:0] w_cmt_count;
  logic             w_alloc_ok;
  logic [CNT_W-1:0] w_rel_cnt;
  logic [CNT_W-1:0] w_rel_off [REL_W];
  logic [TAG_W-1:0] w_wr_idx  [REL_W];
  logic [TAG_W-1:0] w_rd_idx  [ALLOC_W];
  logic [CNT_W:0]   w_rel_need;
  logic             w_rel_ovf;
  logic [CNT_W-1:0] w_wr_ptr;
  logic [CNT_W-1:0] w_rd_ptr;

  assign w_free_count = r_tail - r_spec_head;
  assign w_cmt_count  = r_tail - r_cmt_head;
  assign w_alloc_ok   = (w_free_count >= CNT_W'(bus.alloc_cnt));

  assign bus.alloc_ok     = w_alloc_ok;
  assign bus.free_count   = w_free_count;
  assign bus.empty        = (w_free_count == '0);
  assign bus.overflow_err = r_overflow_err;

  // Present the next ALLOC_W tags from the speculative head, wrapping the index
  always_comb begin
    w_rd_ptr = '0;
    for (int i = 0; i < ALLOC_W; i++) begin
      w_rd_ptr    = r_spec_head + CNT_W'(i);
      w_rd_idx[i] = w_rd_ptr[TAG_W-1:0];
      bus.alloc_tag[i*TAG_W +: TAG_W] = r_ram[w_rd_idx[i]];
    end
  end

  // Compact valid release lanes: each valid lane writes at tail + (valid lanes below it)
  always_comb begin
    w_rel_cnt = '0;
    w_wr_ptr  = '0;
    for (int j = 0; j < REL_W; j++) begin
      w_rel_off[j] = w_rel_cnt;
      w_wr_ptr     = r_tail + w_rel_cnt;
      w_wr_idx[j]  = w_wr_ptr[TAG_W-1:0];
      if (bus.rel_valid[j]) begin
        w_rel_cnt = w_rel_cnt + CNT_W'(1);
      end
    end
    w_rel_need = {1'b0, w_cmt_count} + {1'b0, w_rel_cnt};
    w_rel_ovf  = (w_rel_need > (CNT_W+1)'(NUM_PREG));
  end

  // Pointer, storage and sticky-error update; a flush snaps the speculative head
  // to the post-commit committed head and discards this cycle's allocation
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_PREG; i++) begin
        r_ram[i] <= (i < NUM_PREG - NUM_AREG) ? TAG_W'(NUM_AREG + i) : '0;
      end
      r_spec_head    <= '0;
      r_cmt_head     <= '0;
      r_tail         <= CNT_W'(NUM_PREG - NUM_AREG);
      r_overflow_err <= 1'b0;
    end else begin
      r_cmt_head <= r_cmt_head + CNT_W'(bus.commit_cnt);
      if (bus.flush) begin
        r_spec_head <= r_cmt_head + CNT_W'(bus.commit_cnt);
      end else if (bus.alloc_en && w_alloc_ok) begin
        r_spec_head <= r_spec_head + CNT_W'(bus.alloc_cnt);
      end
      if (w_rel_ovf) begin
        r_overflow_err <= 1'b1;
      end else begin
        for (int j = 0; j < REL_W; j++) begin
          if (bus.rel_valid[j]) begin
            r_ram[w_wr_idx[j]] <= bus.rel_tag[j*TAG_W +: TAG_W];
          end
        end
        r_tail <= r_tail + w_rel_cnt;
      end
    end
  end

endmodule

// File: tb/tb_free_list_ckpt.sv
// Testbench for free_list_ckpt: directed scenarios plus a randomized phase,
// all checked against a queue-based model of the free list.
module tb_free_list_ckpt;
  localparam int NUM_PREG = 64;
  localparam int NUM_AREG = 32;
  localparam int ALLOC_W  = 4;
  localparam int REL_W    = 4;
  localparam int TAG_W    = $clog2(NUM_PREG);
  localparam int CNT_W    = $clog2(NUM_PREG) + 1;
  localparam int AC_W     = $clog2(ALLOC_W) + 1;

  logic clk = 1'b0;
  logic reset;

  free_list_ckpt_if #(.NUM_PREG(NUM_PREG), .ALLOC_W(ALLOC_W), .REL_W(REL_W)) bus ();

  free_list_ckpt #(
    .NUM_PREG(NUM_PREG), .NUM_AREG(NUM_AREG), .ALLOC_W(ALLOC_W), .REL_W(REL_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int errorCount = 0;

  // Stimulus for the current cycle
  logic             sReset;
  int               sAllocCnt;
  logic             sAllocEn;
  logic [REL_W-1:0] sRelValid;
  int               sRelTag [REL_W];
  int               sCommit;
  logic             sFlush;

  // Model: freeQ holds every tag from the committed head to the tail in order;
  // the first specOff of them are speculatively handed out.
  int freeQ[$];
  int specOff;
  bit modelOvf;
  int pool[$];
  int releasable[$];

  task automatic checkOutput(input string tagName, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tagName, observed, expected);
    end
  endtask

  function automatic int modelFree();
    return freeQ.size() - specOff;
  endfunction

  task automatic modelReset();
    freeQ.delete();
    pool.delete();
    releasable.delete();
    for (int i = 0; i < NUM_PREG - NUM_AREG; i++) freeQ.push_back(NUM_AREG + i);
    for (int i = 0; i < NUM_AREG; i++) pool.push_back(i);
    specOff  = 0;
    modelOvf = 0;
  endtask

  task automatic modelStep();
    int relN;
    int cmtCount;
    bit ok;
    int t;
    if (sReset) begin
      modelReset();
      return;
    end
    ok       = (modelFree() >= sAllocCnt);
    cmtCount = freeQ.size();
    relN     = 0;
    for (int j = 0; j < REL_W; j++) if (sRelValid[j]) relN++;
    for (int k = 0; k < sCommit; k++) begin
      t = freeQ.pop_front();
      pool.push_back(t);
      releasable.push_back(pool.pop_front());
    end
    specOff -= sCommit;
    if (sFlush) specOff = 0;
    else if (sAllocEn && ok) specOff += sAllocCnt;
    if (cmtCount + relN > NUM_PREG) modelOvf = 1;
    else for (int j = 0; j < REL_W; j++) if (sRelValid[j]) freeQ.push_back(sRelTag[j]);
  endtask

  task automatic clearStimulus();
    sReset    = 1'b0;
    sAllocCnt = 0;
    sAllocEn  = 1'b0;
    sRelValid = '0;
    for (int j = 0; j < REL_W; j++) sRelTag[j] = 0;
    sCommit   = 0;
    sFlush    = 1'b0;
  endtask

  task automatic applyStimulus();
    reset          = sReset;
    bus.alloc_cnt  = AC_W'(sAllocCnt);
    bus.alloc_en   = sAllocEn;
    bus.rel_valid  = sRelValid;
    for (int j = 0; j < REL_W; j++) bus.rel_tag[j*TAG_W +: TAG_W] = TAG_W'(sRelTag[j]);
    bus.commit_cnt = AC_W'(sCommit);
    bus.flush      = sFlush;
    #1;
  endtask

  task automatic clockStep();
    @(posedge clk);
    #1;
    modelStep();
  endtask

  task automatic checkAgainstModel(input string tagName);
    int nLanes;
    checkOutput({tagName, ".free_count"}, 64'(bus.free_count), 64'(modelFree()));
    checkOutput({tagName, ".empty"}, 64'(bus.empty), 64'(modelFree() == 0));
    checkOutput({tagName, ".alloc_ok"}, 64'(bus.alloc_ok), 64'(modelFree() >= sAllocCnt));
    checkOutput({tagName, ".overflow_err"}, 64'(bus.overflow_err), 64'(modelOvf));
    nLanes = (modelFree() < ALLOC_W) ? modelFree() : ALLOC_W;
    for (int i = 0; i < nLanes; i++)
      checkOutput($sformatf("%s.lane%0d", tagName, i), 64'(bus.alloc_tag[i*TAG_W +: TAG_W]),
                  64'(freeQ[specOff + i]));
  endtask

  task automatic doReset();
    clearStimulus();
    sReset = 1'b1;
    applyStimulus();
    clockStep();
    clearStimulus();
  endtask

  initial begin
    clearStimulus();
    modelReset();
    applyStimulus();

    // Reset then one idle cycle
    doReset();
    applyStimulus();
    clockStep();
    applyStimulus();
    checkOutput("reset.free_count", 64'(bus.free_count), 64'd32);
    checkOutput("reset.empty", 64'(bus.empty), 64'd0);
    checkOutput("reset.overflow_err", 64'(bus.overflow_err), 64'd0);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("reset.lane%0d", i), 64'(bus.alloc_tag[i*TAG_W +: TAG_W]), 64'(32 + i));

    // Drain the list four tags at a time
    for (int k = 0; k < 8; k++) begin
      sAllocCnt = 4;
      sAllocEn  = 1'b1;
      applyStimulus();
      checkOutput("drain.alloc_ok", 64'(bus.alloc_ok), 64'd1);
      for (int i = 0; i < 4; i++)
        checkOutput($sformatf("drain%0d.lane%0d", k, i), 64'(bus.alloc_tag[i*TAG_W +: TAG_W]),
                    64'(32 + 4*k + i));
      clockStep();
    end
    sAllocCnt = 1;
    sAllocEn  = 1'b1;
    applyStimulus();
    checkOutput("empty.free_count", 64'(bus.free_count), 64'd0);
    checkOutput("empty.empty", 64'(bus.empty), 64'd1);
    checkOutput("empty.alloc_ok", 64'(bus.alloc_ok), 64'd0);
    clockStep();

    // Release two tags from empty; no same-cycle bypass
    sAllocCnt  = 1;
    sAllocEn   = 1'b1;
    sRelValid  = 4'b1010;
    sRelTag[0] = 17; sRelTag[1] = 5; sRelTag[2] = 44; sRelTag[3] = 9;
    applyStimulus();
    checkOutput("rel.stall_free_count", 64'(bus.free_count), 64'd0);
    checkOutput("rel.bypass_alloc_ok", 64'(bus.alloc_ok), 64'd0);
    clockStep();
    clearStimulus();
    applyStimulus();
    checkOutput("rel.free_count", 64'(bus.free_count), 64'd2);
    checkOutput("rel.lane0", 64'(bus.alloc_tag[0 +: TAG_W]), 64'd5);
    checkOutput("rel.lane1", 64'(bus.alloc_tag[TAG_W +: TAG_W]), 64'd9);
    checkAgainstModel("rel");

    // Allocate 12, commit 4, then flush while committing 2
    doReset();
    for (int k = 0; k < 3; k++) begin
      sAllocCnt = 4;
      sAllocEn  = 1'b1;
      applyStimulus();
      clockStep();
    end
    clearStimulus();
    sCommit = 4;
    applyStimulus();
    clockStep();
    clearStimulus();
    sCommit   = 2;
    sFlush    = 1'b1;
    sAllocCnt = 3;
    sAllocEn  = 1'b1;
    applyStimulus();
    clockStep();
    clearStimulus();
    applyStimulus();
    checkOutput("flush.free_count", 64'(bus.free_count), 64'd26);
    checkOutput("flush.lane0", 64'(bus.alloc_tag[0 +: TAG_W]), 64'd38);
    checkAgainstModel("flush");

    // Randomized alloc/release/commit/flush traffic
    doReset();
    for (int c = 0; c < 200; c++) begin
      int maxC;
      clearStimulus();
      sAllocCnt = $urandom_range(ALLOC_W);
      sAllocEn  = ($urandom_range(9) < 7);
      maxC      = (specOff < ALLOC_W) ? specOff : ALLOC_W;
      sCommit   = $urandom_range(maxC);
      sFlush    = ($urandom_range(19) == 0);
      for (int j = 0; j < REL_W; j++) begin
        sRelTag[j] = $urandom_range(NUM_PREG - 1);
        if (($urandom_range(1) == 1) && (releasable.size() > 0)) begin
          sRelValid[j] = 1'b1;
          sRelTag[j]   = releasable.pop_front();
        end
      end
      applyStimulus();
      checkAgainstModel($sformatf("rand%0d", c));
      clockStep();
    end
    clearStimulus();
    applyStimulus();
    checkOutput("rand.overflow_err", 64'(bus.overflow_err), 64'd0);

    // Fill to 64 entries, then release one more
    doReset();
    for (int k = 0; k < 8; k++) begin
      sRelValid = 4'b1111;
      for (int j = 0; j < REL_W; j++) sRelTag[j] = 4*k + j;
      applyStimulus();
      clockStep();
    end
    clearStimulus();
    applyStimulus();
    checkOutput("full.free_count", 64'(bus.free_count), 64'd64);
    checkOutput("full.empty", 64'(bus.empty), 64'd0);
    sRelValid  = 4'b0001;
    sRelTag[0] = 3;
    applyStimulus();
    clockStep();
    clearStimulus();
    applyStimulus();
    checkOutput("ovf.overflow_err", 64'(bus.overflow_err), 64'd1);
    checkOutput("ovf.free_count", 64'(bus.free_count), 64'd64);
    checkAgainstModel("ovf");
    doReset();
    applyStimulus();
    checkOutput("ovfrst.overflow_err", 64'(bus.overflow_err), 64'd0);
    checkOutput("ovfrst.free_count", 64'(bus.free_count), 64'd32);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
